// File: rtl/diaosi_types_pkg.sv
// Shared types for the pipeline scoreboard: shadow-pipe entry, forward select
// and the pipe geometry that those types are sized from.
package diaosi_types_pkg;

    // The entry and select types are sized from these, so the geometry
    // lives here rather than as per-instance parameters.
    localparam int NREGS = 32;
    localparam int DEPTH = 3;

    localparam int REG_W = $clog2(NREGS);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FWD_W = $clog2(DEPTH + 1);

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [FWD_W-1:0] fwd_sel_t;

    // Select value meaning "take the operand from the register file".
    localparam fwd_sel_t FWD_REGFILE = '0;

    typedef struct packed {
        logic     valid;
        logic     wen;
        reg_idx_t wsel;
        logic     load;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Priority search of the shadow pipe for the youngest in-flight writer of one
// source register. Register 0 and unused sources never match.
module sb_match
    import diaosi_types_pkg::*;
(
    input  sb_entry_t [DEPTH-1:0] ents_i,
    input  reg_idx_t              src_i,
    input  logic                  use_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  load_o
);

    // Scan oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        load_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (use_i && (src_i != '0) && ents_i[i].valid && ents_i[i].wen &&
                (ents_i[i].wsel == src_i)) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                load_o = ents_i[i].load;
            end
        end
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding controller: shadow pipe of in-flight writers (entry 0 = EX,
// entry DEPTH-1 = WB), per-source forward selects, load-use stall, flush kill,
// and saturating stall/flush statistics.
module pipeline_scoreboard
    import diaosi_types_pkg::*;
#(
    parameter int LOAD_RDY = 2,
    parameter int FLUSH_N  = 1,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             adv,
    input  logic             flush,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs,
    input  logic [REG_W-1:0] dec_rt,
    input  logic             dec_use_rs,
    input  logic             dec_use_rt,
    input  logic             dec_wen,
    input  logic [REG_W-1:0] dec_wsel,
    input  logic             dec_load,
    output logic             stall,
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t [DEPTH-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic             hit_a, hit_b, ld_a, ld_b;
    logic [IDX_W-1:0] idx_a, idx_b;

    sb_match u_match_a (
        .ents_i (pipe_q),
        .src_i  (dec_rs),
        .use_i  (dec_use_rs),
        .hit_o  (hit_a),
        .idx_o  (idx_a),
        .load_o (ld_a)
    );

    sb_match u_match_b (
        .ents_i (pipe_q),
        .src_i  (dec_rt),
        .use_i  (dec_use_rt),
        .hit_o  (hit_b),
        .idx_o  (idx_b),
        .load_o (ld_b)
    );

    // Stall while a winning match is a load whose data is not yet forwardable;
    // selects come straight from pipe state so they stay stable during a stall.
    always_comb begin
        stall = (hit_a && ld_a && (int'(idx_a) < LOAD_RDY)) ||
                (hit_b && ld_b && (int'(idx_b) < LOAD_RDY));
        fwd_a = hit_a ? fwd_sel_t'(idx_a) + fwd_sel_t'(1) : FWD_REGFILE;
        fwd_b = hit_b ? fwd_sel_t'(idx_b) + fwd_sel_t'(1) : FWD_REGFILE;
    end

    // Shift on advance (bubble when stalled or flushed), then kill the
    // youngest FLUSH_N entries on flush whether or not the pipe moved.
    always_comb begin
        pipe_d = pipe_q;
        if (adv) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                pipe_d[i] = pipe_q[i-1];
            end
            pipe_d[0] = '0;
            if (dec_valid && !stall && !flush) begin
                pipe_d[0].valid = 1'b1;
                pipe_d[0].wen   = dec_wen;
                pipe_d[0].wsel  = dec_wsel;
                pipe_d[0].load  = dec_load;
            end
        end
        if (flush) begin
            for (int i = 0; i < FLUSH_N; i++) begin
                pipe_d[i].valid = 1'b0;
            end
        end
    end

    // Saturating statistics; a flush cycle never counts as a stall cycle.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && adv && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset discarding all in-flight entries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pipe_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Bench for pipeline_scoreboard: directed vector table, a saturation sequence
// and a randomized run against an age-ordered writer-list reference model.
module tb_pipeline_scoreboard;
    import diaosi_types_pkg::*;

    localparam int LRDY = 2;
    localparam int FLN  = 1;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic             RST, adv, flush, dec_valid, dec_use_rs, dec_use_rt, dec_wen, dec_load;
    logic [REG_W-1:0] dec_rs, dec_rt, dec_wsel;
    logic             stall, stall4;
    logic [FWD_W-1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic [31:0]      stall_cnt, flush_cnt;
    logic [3:0]       stall_cnt4, flush_cnt4;

    pipeline_scoreboard #(.LOAD_RDY(LRDY), .FLUSH_N(FLN), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_wen(dec_wen), .dec_wsel(dec_wsel), .dec_load(dec_load),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_scoreboard #(.LOAD_RDY(LRDY), .FLUSH_N(FLN), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .adv(adv), .flush(flush), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_wen(dec_wen), .dec_wsel(dec_wsel), .dec_load(dec_load),
        .stall(stall4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        bit rst, adv, flush, dv;
        int rs, rt;
        bit urs, urt, wen;
        int wsel;
        bit ld;
        bit e_stall;
        int e_fa, e_fb;     // -1: don't care (stalled)
        int e_scnt, e_fcnt;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    // Reference model: destination register per age slot (0 = nothing that
    // can hazard), plus whether that slot is a load; counters kept unbounded.
    int     m_dst[DEPTH];
    bit     m_ld[DEPTH];
    longint m_scnt = 0, m_fcnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint x, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic int m_fwd(input int s, input bit u);
        if (!u || s == 0) return 0;
        for (int k = 0; k < DEPTH; k++) if (m_dst[k] == s) return k + 1;
        return 0;
    endfunction

    function automatic bit m_late(input int f);
        return (f != 0) && m_ld[f-1] && ((f - 1) < LRDY);
    endfunction

    task automatic m_update(input vec_t v, input bit st);
        if (v.rst) begin
            for (int k = 0; k < DEPTH; k++) begin m_dst[k] = 0; m_ld[k] = 0; end
            m_scnt = 0;
            m_fcnt = 0;
            return;
        end
        if (v.adv) begin
            for (int k = DEPTH - 1; k > 0; k--) begin m_dst[k] = m_dst[k-1]; m_ld[k] = m_ld[k-1]; end
            if (v.dv && !st && !v.flush && v.wen) begin m_dst[0] = v.wsel; m_ld[0] = v.ld; end
            else begin m_dst[0] = 0; m_ld[0] = 0; end
            if (st && !v.flush) m_scnt++;
        end
        if (v.flush) begin
            for (int k = 0; k < FLN; k++) begin m_dst[k] = 0; m_ld[k] = 0; end
            m_fcnt++;
        end
    endtask

    task automatic step(input vec_t v, input bit use_tab, input string tag);
        int fa, fb;
        bit st;
        @(negedge CLK);
        RST = v.rst; adv = v.adv; flush = v.flush; dec_valid = v.dv;
        dec_rs = REG_W'(v.rs); dec_rt = REG_W'(v.rt);
        dec_use_rs = v.urs; dec_use_rt = v.urt; dec_wen = v.wen;
        dec_wsel = REG_W'(v.wsel); dec_load = v.ld;
        #1;
        fa = m_fwd(v.rs, v.urs);
        fb = m_fwd(v.rt, v.urt);
        st = m_late(fa) || m_late(fb);
        if (model_on) begin
            chk({tag, " model stall"}, stall, st);
            chk({tag, " model stall4"}, stall4, st);
            if (!st) begin
                chk({tag, " model fwd_a"}, fwd_a, fa);
                chk({tag, " model fwd_b"}, fwd_b, fb);
            end
            chk({tag, " model stall_cnt"}, stall_cnt, sat(m_scnt, 32));
            chk({tag, " model flush_cnt"}, flush_cnt, sat(m_fcnt, 32));
            chk({tag, " model stall_cnt4"}, stall_cnt4, sat(m_scnt, 4));
            chk({tag, " model flush_cnt4"}, flush_cnt4, sat(m_fcnt, 4));
        end
        if (use_tab) begin
            chk({tag, " stall"}, stall, v.e_stall);
            if (v.e_fa >= 0) chk({tag, " fwd_a"}, fwd_a, v.e_fa);
            if (v.e_fb >= 0) chk({tag, " fwd_b"}, fwd_b, v.e_fb);
            chk({tag, " stall_cnt"}, stall_cnt, v.e_scnt);
            chk({tag, " flush_cnt"}, flush_cnt, v.e_fcnt);
        end
        @(posedge CLK);
        m_update(v, st);
    endtask

    function automatic vec_t mk(bit a, bit f, bit dv, int rs, int rt, bit urs, bit urt,
                                bit wen, int wsel, bit ld, bit es, int efa, int efb,
                                int esc, int efc);
        vec_t v;
        v.rst = 0; v.adv = a; v.flush = f; v.dv = dv; v.rs = rs; v.rt = rt;
        v.urs = urs; v.urt = urt; v.wen = wen; v.wsel = wsel; v.ld = ld;
        v.e_stall = es; v.e_fa = efa; v.e_fb = efb; v.e_scnt = esc; v.e_fcnt = efc;
        return v;
    endfunction

    function automatic vec_t rnd(bit r);
        vec_t v;
        v.rst = r;
        v.adv = ($urandom_range(0, 4) != 0);
        v.flush = ($urandom_range(0, 9) == 0);
        v.dv = ($urandom_range(0, 7) != 0);
        v.rs = $urandom_range(0, 7); v.rt = $urandom_range(0, 7);
        v.urs = $urandom_range(0, 1); v.urt = $urandom_range(0, 1);
        v.wen = ($urandom_range(0, 3) != 0); v.wsel = $urandom_range(0, 7);
        v.ld = ($urandom_range(0, 2) == 0);
        v.e_stall = 0; v.e_fa = 0; v.e_fb = 0; v.e_scnt = 0; v.e_fcnt = 0;
        return v;
    endfunction

    vec_t tab[21];

    initial begin
        vec_t v;
        RST = 1; adv = 0; flush = 0; dec_valid = 0; dec_rs = '0; dec_rt = '0;
        dec_use_rs = 0; dec_use_rt = 0; dec_wen = 0; dec_wsel = '0; dec_load = 0;
        for (int k = 0; k < DEPTH; k++) begin m_dst[k] = 0; m_ld[k] = 0; end

        //             adv fl dv rs  rt urs urt wen wsel ld  st  fa  fb sc fc
        tab[0]  = mk(1, 0, 1,  1,  2, 1, 1, 1,  3, 0,  0,  0,  0, 0, 0); // add $3,$1,$2
        tab[1]  = mk(1, 0, 1,  3,  5, 1, 1, 1,  4, 0,  0,  1,  0, 0, 0); // sub $4,$3,$5: EX fwd
        tab[2]  = mk(1, 0, 1,  3,  0, 1, 1, 1,  6, 0,  0,  2,  0, 0, 0); // $3 from MEM
        tab[3]  = mk(1, 0, 1,  3,  3, 1, 1, 1,  7, 0,  0,  3,  3, 0, 0); // $3 from WB
        tab[4]  = mk(1, 0, 1,  7,  8, 1, 0, 1,  8, 1,  0,  1,  0, 0, 0); // lw $8,0($7)
        tab[5]  = mk(1, 0, 1,  1,  2, 1, 1, 1, 10, 0,  0,  0,  0, 0, 0); // independent
        tab[6]  = mk(1, 0, 1,  8,  8, 1, 1, 1,  9, 0,  1, -1, -1, 0, 0); // add $9,$8,$8 stalls
        tab[7]  = mk(1, 0, 1,  8,  8, 1, 1, 1,  9, 0,  0,  3,  3, 1, 0); // load data from MEM out
        tab[8]  = mk(1, 0, 1,  0,  0, 0, 0, 1,  5, 0,  0,  0,  0, 1, 0); // write $5
        tab[9]  = mk(1, 0, 1,  0,  0, 0, 0, 1, 11, 0,  0,  0,  0, 1, 0);
        tab[10] = mk(1, 0, 1,  0,  0, 0, 0, 1,  5, 0,  0,  0,  0, 1, 0); // write $5 again
        tab[11] = mk(1, 0, 1,  5,  0, 1, 1, 1,  0, 0,  0,  1,  0, 1, 0); // youngest $5 wins
        tab[12] = mk(1, 0, 1,  0,  5, 1, 1, 0,  0, 0,  0,  0,  2, 1, 0); // $0 writer ignored
        tab[13] = mk(1, 1, 1,  0,  0, 0, 0, 1, 12, 0,  0,  0,  0, 1, 0); // flush + issue
        tab[14] = mk(1, 0, 1, 12, 12, 1, 1, 0,  0, 0,  0,  0,  0, 1, 1); // $12 never entered
        tab[15] = mk(1, 0, 1,  0,  0, 0, 0, 1, 13, 1,  0,  0,  0, 1, 1); // lw $13
        tab[16] = mk(0, 0, 1, 13,  0, 1, 1, 1, 14, 0,  1, -1, -1, 1, 1); // adv=0: frozen
        tab[17] = mk(0, 0, 1, 13,  0, 1, 1, 1, 14, 0,  1, -1, -1, 1, 1);
        tab[18] = mk(1, 0, 1, 13,  0, 1, 1, 1, 14, 0,  1, -1, -1, 1, 1);
        tab[19] = mk(1, 0, 1, 13,  0, 1, 1, 1, 14, 0,  1, -1, -1, 2, 1);
        tab[20] = mk(1, 0, 1, 13,  0, 1, 1, 1, 14, 0,  0,  3,  0, 3, 1);

        // Reset held two cycles with random decode inputs, then checked.
        step(rnd(1), 0, "rst0");
        step(rnd(1), 0, "rst1");
        model_on = 1;
        step(rnd(1), 1, "rst_chk");

        for (int i = 0; i < 21; i++) step(tab[i], 1, $sformatf("vec%0d", i));

        // Ten load-use pairs, two stall cycles each: narrow counter saturates.
        for (int i = 0; i < 10; i++) begin
            step(mk(1, 0, 1, 0, 0, 0, 0, 1, 14, 1, 0, 0, 0, 0, 0), 0, "sat_lw");
            for (int j = 0; j < 3; j++)
                step(mk(1, 0, 1, 14, 0, 1, 0, 1, 15, 0, 0, 0, 0, 0, 0), 0, "sat_use");
        end
        @(negedge CLK);
        chk("sat stall_cnt4", stall_cnt4, 15);
        chk("sat stall_cnt", stall_cnt, 23);

        for (int i = 0; i < 2000; i++) begin
            v = rnd($urandom_range(0, 99) == 0);
            step(v, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
